// File: rtl/perips_icb_bridge_if.sv
// Core data-side request/response port plus the peripheral ICB strobe bus,
// bundled so the bridge and its environment share one connection.
// master: core + peripheral side (drives requests and acks).
// slave : the bridge (drives ready, responses and strobes).
interface perips_icb_bridge_if;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_req_we;
    logic [31:0] cpu_req_addr;
    logic [31:0] cpu_req_wdat;
    logic        cpu_rsp_valid;
    logic        cpu_rsp_ready;
    logic [31:0] cpu_rsp_rdat;
    logic        cpu_rsp_err;
    logic        icb_wr;
    logic [19:0] icb_wadr;
    logic [31:0] icb_wdat;
    logic        icb_wack;
    logic        icb_rd;
    logic [19:0] icb_radr;
    logic [31:0] icb_rdat;
    logic        icb_rack;

    modport master (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdat,
        output cpu_rsp_ready, icb_wack, icb_rdat, icb_rack,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdat, cpu_rsp_err,
        input  icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr
    );

    modport slave (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdat,
        input  cpu_rsp_ready, icb_wack, icb_rdat, icb_rack,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdat, cpu_rsp_err,
        output icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr
    );
endinterface

// File: rtl/perips_icb_bridge.sv
// Single-outstanding bridge from the core data port to the peripheral ICB
// strobe bus. Decodes the peripheral window, holds the strobe until the
// matching ack or a timeout, and returns a response with an error flag.
module perips_icb_bridge #(
    parameter logic [11:0] BASE_HI = 12'h100,
    parameter int          TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    perips_icb_bridge_if.slave  bus,
    output logic [7:0]          err_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WR_REQ = 2'd1;
    localparam logic [1:0] RD_REQ = 2'd2;
    localparam logic [1:0] RSP    = 2'd3;

    // Strobe-cycle counter is at least 5 bits wide, wider for big TIMEOUT.
    localparam int CNT_W = ($clog2(TIMEOUT) > 5) ? $clog2(TIMEOUT) : 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             req_ready;
    logic             rsp_valid;
    logic [31:0]      rsp_rdat;
    logic             rsp_err;
    logic             wr;
    logic [19:0]      wadr;
    logic [31:0]      wdat;
    logic             rd;
    logic [19:0]      radr;

    // Address lies in the peripheral window and is word aligned.
    function automatic logic addr_ok(input logic [31:0] addr);
        return (addr[31:20] == BASE_HI) && (addr[1:0] == 2'b00);
    endfunction

    // Error counter sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

    assign bus.cpu_req_ready = req_ready;
    assign bus.cpu_rsp_valid = rsp_valid;
    assign bus.cpu_rsp_rdat  = rsp_rdat;
    assign bus.cpu_rsp_err   = rsp_err;
    assign bus.icb_wr        = wr;
    assign bus.icb_wadr      = wadr;
    assign bus.icb_wdat      = wdat;
    assign bus.icb_rd        = rd;
    assign bus.icb_radr      = radr;

    // Request/strobe/response sequencing; every output is a register here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdat  <= '0;
            rsp_err   <= 1'b0;
            wr        <= 1'b0;
            wadr      <= '0;
            wdat      <= '0;
            rd        <= 1'b0;
            radr      <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        cnt       <= '0;
                        if (!addr_ok(bus.cpu_req_addr)) begin
                            // Decode/alignment error: answer directly, no ICB cycle.
                            state     <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdat  <= '0;
                            err_cnt   <= sat_inc(err_cnt);
                        end else if (bus.cpu_req_we) begin
                            state <= WR_REQ;
                            wr    <= 1'b1;
                            wadr  <= bus.cpu_req_addr[19:0];
                            wdat  <= bus.cpu_req_wdat;
                        end else begin
                            state <= RD_REQ;
                            rd    <= 1'b1;
                            radr  <= bus.cpu_req_addr[19:0];
                        end
                    end
                end
                WR_REQ: begin
                    if (bus.icb_wack) begin
                        state     <= RSP;
                        wr        <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdat  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= RSP;
                        wr        <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdat  <= '0;
                        err_cnt   <= sat_inc(err_cnt);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RD_REQ: begin
                    if (bus.icb_rack) begin
                        state     <= RSP;
                        rd        <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdat  <= bus.icb_rdat;
                    end else if (cnt == CNT_LAST) begin
                        state     <= RSP;
                        rd        <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdat  <= '0;
                        err_cnt   <= sat_inc(err_cnt);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // RSP: hold the response until the core takes it.
                    if (bus.cpu_rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdat  <= '0;
                        req_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perips_icb_bridge.sv
// Bench for perips_icb_bridge: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_perips_icb_bridge;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] err_cnt;
    int         checks = 0;
    int         errors = 0;
    int         exp_errs = 0;

    always #5 clk = ~clk;

    perips_icb_bridge_if bus();

    perips_icb_bridge #(.BASE_HI(12'h100), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .err_cnt (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction. d = strobe cycle index (0-based) at which the
    // peripheral acks; d >= TIMEOUT means it never acks. hold = cycles the
    // core stalls the response. noise drives the wrong-type ack randomly.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input int d, input logic [31:0] rdin, input int hold, input bit noise);
        bit          dec_err, exp_err, seen, strobe;
        int          exp_s, s;
        logic [31:0] exp_rdat;
        dec_err  = (addr[31:20] != 12'h100) || (addr[1:0] != 2'b00);
        exp_s    = dec_err ? 0 : ((d < TIMEOUT) ? d + 1 : TIMEOUT);
        exp_err  = dec_err || (d >= TIMEOUT);
        exp_rdat = (!exp_err && !we) ? rdin : 32'h0;
        if (exp_err) exp_errs = (exp_errs >= 255) ? 255 : exp_errs + 1;

        @(negedge clk);
        chk("req_ready_idle", bus.cpu_req_ready, 1);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_we    = we;
        bus.cpu_req_addr  = addr;
        bus.cpu_req_wdat  = wd;
        bus.cpu_rsp_ready = (hold == 0);
        s    = 0;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            bus.cpu_req_valid = 1'b0;
            bus.cpu_req_addr  = $urandom;
            bus.cpu_req_wdat  = $urandom;
            chk("no_dual_strobe", {31'b0, bus.icb_wr & bus.icb_rd}, 0);
            if (bus.cpu_rsp_valid) begin
                seen = 1'b1;
                chk("rsp_latency", k, exp_s + 1);
                chk("strobe_cycles", s, exp_s);
            end else begin
                chk("req_ready_busy", bus.cpu_req_ready, 0);
                strobe = we ? bus.icb_wr : bus.icb_rd;
                if (we) begin
                    chk("rd_quiet", bus.icb_rd, 0);
                    if (strobe) begin
                        chk("wadr", bus.icb_wadr, addr[19:0]);
                        chk("wdat", bus.icb_wdat, wd);
                    end
                end else begin
                    chk("wr_quiet", bus.icb_wr, 0);
                    if (strobe) chk("radr", bus.icb_radr, addr[19:0]);
                end
                if (strobe) s++;
                bus.icb_wack = we && strobe && (s - 1 == d);
                bus.icb_rack = !we && strobe && (s - 1 == d);
                bus.icb_rdat = bus.icb_rack ? rdin : $urandom;
                if (noise) begin
                    if (we) bus.icb_rack = 1'($urandom_range(0, 1));
                    else    bus.icb_wack = 1'($urandom_range(0, 1));
                end
            end
        end
        bus.icb_wack = 1'b0;
        bus.icb_rack = 1'b0;
        chk("rsp_seen", {31'b0, seen}, 1);
        chk("rsp_err", bus.cpu_rsp_err, exp_err);
        chk("rsp_rdat", bus.cpu_rsp_rdat, exp_rdat);
        chk("err_cnt_rsp", err_cnt, exp_errs);
        for (int h = 0; h < hold; h++) begin
            bus.cpu_req_valid = 1'b1;
            bus.cpu_req_addr  = 32'h1000_0100;
            @(negedge clk);
            chk("hold_valid", bus.cpu_rsp_valid, 1);
            chk("hold_rdat", bus.cpu_rsp_rdat, exp_rdat);
            chk("hold_err", bus.cpu_rsp_err, exp_err);
            chk("hold_req_ready", bus.cpu_req_ready, 0);
            chk("hold_no_strobe", {31'b0, bus.icb_wr | bus.icb_rd}, 0);
        end
        bus.cpu_req_valid = 1'b0;
        bus.cpu_rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_taken", bus.cpu_rsp_valid, 0);
        chk("req_ready_back", bus.cpu_req_ready, 1);
        chk("err_cnt_after", err_cnt, exp_errs);
    endtask

    initial begin
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_we    = 1'b0;
        bus.cpu_req_addr  = '0;
        bus.cpu_req_wdat  = '0;
        bus.cpu_rsp_ready = 1'b1;
        bus.icb_wack      = 1'b0;
        bus.icb_rack      = 1'b0;
        bus.icb_rdat      = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req_ready", bus.cpu_req_ready, 1);
        chk("rst_rsp_valid", bus.cpu_rsp_valid, 0);
        chk("rst_rsp_err", bus.cpu_rsp_err, 0);
        chk("rst_rsp_rdat", bus.cpu_rsp_rdat, 0);
        chk("rst_icb_wr", bus.icb_wr, 0);
        chk("rst_icb_rd", bus.icb_rd, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b1;

        // Directed scenarios.
        txn(1'b1, 32'h1000_0404, 32'hDEADBEEF, 0, 32'h0, 0, 1'b0);
        txn(1'b0, 32'h1000_1008, 32'h0, 3, 32'h1234_5678, 0, 1'b0);
        txn(1'b0, 32'h2000_0000, 32'h0, 0, 32'h5555_5555, 0, 1'b0);
        txn(1'b1, 32'h1000_0002, 32'h1111_2222, 0, 32'h0, 0, 1'b0);
        chk("err_cnt_two", err_cnt, 2);
        txn(1'b1, 32'h1000_0020, 32'hCAFE_F00D, 100, 32'h0, 0, 1'b0);
        // Late write ack after the timeout must have no effect.
        bus.icb_wack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("late_wack_wr", bus.icb_wr, 0);
            chk("late_wack_rsp", bus.cpu_rsp_valid, 0);
            chk("late_wack_ready", bus.cpu_req_ready, 1);
            chk("late_wack_errcnt", err_cnt, exp_errs);
        end
        bus.icb_wack = 1'b0;
        txn(1'b0, 32'h1000_0030, 32'h0, 1, 32'hA5A5_0F0F, 5, 1'b0);
        txn(1'b0, 32'h1000_0040, 32'h0, 100, 32'h0, 2, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = {12'h100, 18'($urandom), 2'b00};
            if ($urandom_range(0, 4) == 0) a = $urandom;
            txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 20),
                $urandom, $urandom_range(0, 3), 1'b1);
        end

        // Reset in the middle of a read strobe.
        @(negedge clk);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_we    = 1'b0;
        bus.cpu_req_addr  = 32'h1000_0010;
        bus.cpu_rsp_ready = 1'b1;
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        chk("midrst_rd_on", bus.icb_rd, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rd", bus.icb_rd, 0);
        chk("midrst_rsp_valid", bus.cpu_rsp_valid, 0);
        chk("midrst_req_ready", bus.cpu_req_ready, 1);
        chk("midrst_err_cnt", err_cnt, 0);
        rst = 1'b1;
        exp_errs = 0;

        // Error counter saturation.
        for (int i = 0; i < 260; i++)
            txn(1'($urandom_range(0, 1)), 32'h2000_0000, 32'h0, 0, 32'h0, 0, 1'b0);
        chk("err_cnt_sat", err_cnt, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
